param_handshake_memory: RTL and testbench



---
 rtl/param_handshake_memory_if.sv | 28 ++
 rtl/param_handshake_memory.sv | 116 +++++++++++
 tb/tb_param_handshake_memory.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_handshake_memory_if.sv
// Request/response bus between the core's memory stage and param_handshake_memory.
// Handshake: the requester raises memory_rden and/or memory_wren and holds it until it sees
// the one-cycle memory_response pulse; requests seen while memory_busy is high are ignored.
interface param_handshake_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   memory_addr;
    logic                memory_rden;
    logic                memory_wren;
    logic [DATA_W/8-1:0] memory_byteen;
    logic [DATA_W-1:0]   memory_write_val;
    logic [DATA_W-1:0]   memory_read_val;
    logic                memory_response;
    logic                memory_error;
    logic                memory_busy;
    logic [1:0]          dbg_state;

    modport master (
        output memory_addr, memory_rden, memory_wren, memory_byteen, memory_write_val,
        input  memory_read_val, memory_response, memory_error, memory_busy, dbg_state
    );

    modport slave (
        input  memory_addr, memory_rden, memory_wren, memory_byteen, memory_write_val,
        output memory_read_val, memory_response, memory_error, memory_busy, dbg_state
    );
endinterface

// File: rtl/param_handshake_memory.sv
// Single-outstanding-request data memory with configurable width, depth and latency,
// byte-enabled writes, out-of-range error reporting and a busy flag.
module param_handshake_memory #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    param_handshake_memory_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        READY = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [ADDR_W-1:0]  addr_q;
    logic               wr_q;
    logic [BYTES-1:0]   be_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  read_val, read_val_nx;
    logic               response, response_nx;
    logic               error, error_nx;
    logic               capture, access, in_range;
    logic [IDX_W-1:0]   idx;

    logic [DATA_W-1:0]  mem [DEPTH] = '{default: '0};

    assign capture  = (state == READY) && (bus.memory_rden || bus.memory_wren);
    assign access   = (state == WAIT) && (cnt == '0);
    // Full-width compare so an address that would alias after truncation is still an error.
    assign in_range = ({1'b0, addr_q} < DEPTH_X);
    assign idx      = addr_q[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= READY;
            cnt      <= '0;
            read_val <= '0;
            response <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            read_val <= read_val_nx;
            response <= response_nx;
            error    <= error_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            addr_q  <= bus.memory_addr;
            wr_q    <= bus.memory_wren;
            be_q    <= bus.memory_byteen;
            wdata_q <= bus.memory_write_val;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        read_val_nx = read_val;
        response_nx = 1'b0;
        error_nx    = 1'b0;
        case (state)
            READY: begin
                if (capture) begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    state_nx    = RESP;
                    response_nx = 1'b1;
                    error_nx    = !in_range;
                    if (!wr_q) read_val_nx = in_range ? mem[idx] : '0;
                end
            end
            RESP:    state_nx = READY;
            default: state_nx = READY;
        endcase
    end

    // Commit happens only on the access edge, so a reset during WAIT drops the write.
    always_ff @(posedge clk) begin
        if (access && wr_q && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign bus.memory_read_val = read_val;
    assign bus.memory_response = response;
    assign bus.memory_error    = error;
    assign bus.memory_busy     = (state != READY);
    assign bus.dbg_state       = state;
endmodule

// File: tb/tb_param_handshake_memory.sv
// Bench for param_handshake_memory: three instances (LATENCY 2, 4, 1) checked against a
// transaction-level model of the word array and the last-read value.
module tb_param_handshake_memory;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [3];
    logic [31:0] addr_d  [3];
    logic        rden_d  [3];
    logic        wren_d  [3];
    logic [3:0]  be_d    [3];
    logic [31:0] wval_d  [3];
    logic [31:0] rv      [3];
    logic        resp    [3];
    logic        err     [3];
    logic        busy    [3];
    int          lat_of  [3] = '{2, 4, 1};

    logic [31:0] model_mem [3][1024];
    logic [31:0] exp_rv    [3];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 4 : 1);
        param_handshake_memory_if #(.DATA_W(32), .ADDR_W(32)) bus ();
        assign bus.memory_addr      = addr_d[k];
        assign bus.memory_rden      = rden_d[k];
        assign bus.memory_wren      = wren_d[k];
        assign bus.memory_byteen    = be_d[k];
        assign bus.memory_write_val = wval_d[k];
        assign rv[k]   = bus.memory_read_val;
        assign resp[k] = bus.memory_response;
        assign err[k]  = bus.memory_error;
        assign busy[k] = bus.memory_busy;
        param_handshake_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(LAT)) dut (
            .clk   (clk),
            .rst_n (rst_n[k]),
            .bus   (bus)
        );
    end

    // One complete request on instance k: drive, wait for the response, check it and the idle cycle after.
    task automatic txn(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d, input bit scramble);
        int n;
        bit got;
        bit oob;
        logic [31:0] want;
        @(negedge clk);
        n_cmp++;
        if (busy[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_busy dut%0d: got %b want 0", k, busy[k]);
        end
        addr_d[k] = a; rden_d[k] = rd; wren_d[k] = wr; be_d[k] = be; wval_d[k] = d;
        oob = (a >= 32'd1024);
        if (!wr) exp_rv[k] = oob ? 32'h0 : model_mem[k][a[9:0]];
        exp_q.push_back(exp_rv[k]);
        if (wr && !oob) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[k][a[9:0]][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            n_cmp++;
            if (busy[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL wait_busy dut%0d addr %h: got %b want 1", k, a, busy[k]);
            end
            if (scramble) begin
                addr_d[k] = $urandom; rden_d[k] = 1'($urandom_range(0, 1));
                wren_d[k] = 1'($urandom_range(0, 1)); be_d[k] = 4'($urandom); wval_d[k] = $urandom;
            end
            @(posedge clk); #1;
            n++;
            if (resp[k] === 1'b1) got = 1'b1;
        end
        want = exp_q.pop_front();
        rden_d[k] = 1'b0; wren_d[k] = 1'b0;
        n_cmp++;
        if (!got || n != lat_of[k]) begin
            n_bad++;
            $display("FAIL latency dut%0d addr %h: got %0d edges (seen=%0d) want %0d", k, a, n, got, lat_of[k]);
        end
        n_cmp++;
        if (err[k] !== oob) begin
            n_bad++;
            $display("FAIL error dut%0d addr %h: got %b want %b", k, a, err[k], oob);
        end
        n_cmp++;
        if (rv[k] !== want) begin
            n_bad++;
            $display("FAIL read_val dut%0d addr %h: got %h want %h", k, a, rv[k], want);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (resp[k] !== 1'b0 || err[k] !== 1'b0 || busy[k] !== 1'b0 || rv[k] !== exp_rv[k]) begin
            n_bad++;
            $display("FAIL after_resp dut%0d: got resp=%b err=%b busy=%b rv=%h want 0/0/0/%h",
                     k, resp[k], err[k], busy[k], rv[k], exp_rv[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; addr_d[k] = '0; rden_d[k] = 1'b0; wren_d[k] = 1'b0;
            be_d[k] = '0; wval_d[k] = '0; exp_rv[k] = '0;
            for (int i = 0; i < 1024; i++) model_mem[k][i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rv[k] !== 32'h0 || resp[k] !== 1'b0 || err[k] !== 1'b0 || busy[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got rv=%h resp=%b err=%b busy=%b want all 0", k, rv[k], resp[k], err[k], busy[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    endtask

    task automatic test_basic();
        txn(0, 0, 1, 32'd5, 4'hF, 32'hDEADBEEF, 0);
        txn(0, 1, 0, 32'd5, 4'h0, 32'h0, 0);
    endtask

    task automatic test_byteen();
        txn(0, 0, 1, 32'd7, 4'hF, 32'h11223344, 0);
        txn(0, 0, 1, 32'd7, 4'b0101, 32'hAABBCCDD, 0);
        txn(0, 1, 0, 32'd7, 4'h0, 32'h0, 0);
        n_cmp++;
        if (rv[0] !== 32'h11BB33DD) begin
            n_bad++;
            $display("FAIL byteen_merge: got %h want 11bb33dd", rv[0]);
        end
        txn(0, 0, 1, 32'd7, 4'b0000, 32'hFFFFFFFF, 0);
        txn(0, 1, 0, 32'd7, 4'h0, 32'h0, 0);
    endtask

    task automatic test_out_of_range();
        txn(0, 1, 0, 32'd1024, 4'h0, 32'h0, 0);
        txn(0, 0, 1, 32'hFFFFFFFF, 4'hF, 32'h12345678, 0);
        txn(0, 1, 0, 32'd1023, 4'h0, 32'h0, 0);
        txn(0, 0, 1, 32'h80000005, 4'hF, 32'h0BADF00D, 0);
        txn(0, 1, 0, 32'd5, 4'h0, 32'h0, 0);
        txn(0, 1, 0, 32'h80000005, 4'h0, 32'h0, 0);
    endtask

    task automatic test_simultaneous_and_busy();
        txn(0, 1, 1, 32'd3, 4'hF, 32'h5, 0);
        txn(0, 1, 0, 32'd3, 4'h0, 32'h0, 0);
        txn(0, 0, 1, 32'd4, 4'hF, 32'hA5A5A5A5, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (resp[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL extra_pulse cycle %0d: got resp=%b want 0", i, resp[0]);
            end
        end
        txn(0, 1, 0, 32'd4, 4'h0, 32'h0, 0);
    endtask

    task automatic test_reset_mid_write();
        txn(1, 0, 1, 32'd2, 4'hF, 32'h1234, 0);
        txn(1, 1, 0, 32'd2, 4'h0, 32'h0, 0);
        @(negedge clk);
        addr_d[1] = 32'd9; wren_d[1] = 1'b1; be_d[1] = 4'hF; wval_d[1] = 32'hCAFE;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 rst_n[1] = 1'b0;
        #1;
        exp_rv[1] = '0;
        n_cmp++;
        if (rv[1] !== 32'h0 || resp[1] !== 1'b0 || err[1] !== 1'b0 || busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got rv=%h resp=%b err=%b busy=%b want all 0", rv[1], resp[1], err[1], busy[1]);
        end
        wren_d[1] = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n[1] = 1'b1;
        txn(1, 1, 0, 32'd9, 4'h0, 32'h0, 0);
        txn(1, 1, 0, 32'd2, 4'h0, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            bit w;
            w = 1'($urandom_range(0, 1));
            txn(2, !w, w, 32'($urandom_range(0, 7)), 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int sel;
            bit r, w;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = 32'($urandom_range(0, 15));
            else if (sel == 8) a = 32'($urandom_range(1020, 1030));
            else               a = $urandom;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            txn(0, r, w, a, 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byteen();
        test_out_of_range();
        test_simultaneous_and_busy();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
